operand_fetch: RTL and testbench
================================

OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 Parameter: DW, 32, data width of register and operand values.
REQ-002 Parameter: AW, 5, register address width (32 registers, r0 hard-wired zero).
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 in_valid_i  in  1  decoded instruction present. in_ready_o  out  1  instruction accepted this cycle.
REQ-007 in_ra0_i, in_ra1_i  in  AW  source register indices. in_wa_i  in  AW  destination index. in_we_i  in  1  instruction writes destination.
REQ-008 ra0_o, ra1_o  out  AW  regfile read addresses. rd0_i, rd1_i  in  DW  regfile read data (combinational read).
REQ-009 wb_valid_i  in  1  writeback this cycle (same signal driving the regfile write enable). wb_wa_i  in  AW  writeback index. wb_wd_i  in  DW  writeback data.
REQ-010 out_valid_o  out  1  operands valid. out_ready_i  in  1  downstream accepts.
REQ-011 out_op0_o, out_op1_o  out  DW  operands. out_wa_o  out  AW  destination. out_we_o  out  1  writes destination.
REQ-012 busy_o  out  2^AW  scoreboard bit vector (debug/verification).

Function
REQ-013 ra0_o/ra1_o SHALL equal in_ra0_i/in_ra1_i combinationally at all times.
REQ-014 Scoreboard: one busy bit per register; bit 0 SHALL never be set.
REQ-015 cleared(r) = wb_valid_i and wb_wa_i == r; effective busy(r) = busy[r] and not cleared(r).
REQ-016 hazard = in_valid_i and (eff-busy(in_ra0_i) or eff-busy(in_ra1_i) or (in_we_i and eff-busy(in_wa_i))); index 0 never hazards.
REQ-017 Output slot has two states, EMPTY (out_valid_o=0) and FULL (out_valid_o=1).
REQ-018 in_ready_o = not hazard and (EMPTY or out_ready_i); combinational, independent of in_valid_i for the slot term.
REQ-019 Operand select per source: index 0 -> 0; else if cleared(index) -> wb_wd_i (bypass); else -> rdN_i.
REQ-020 Accept (in_valid_i and in_ready_o) at edge: load operands, in_wa_i, in_we_i into slot; state -> FULL.
REQ-021 FULL with out_ready_i and no accept: state -> EMPTY; payload holds last value.
REQ-022 FULL without out_ready_i: payload and out_valid_o SHALL stay stable.
REQ-023 Accept with in_we_i=1 and in_wa_i!=0 SHALL set busy[in_wa_i]; accept with in_wa_i=0 sets nothing and out_we_o SHALL be 0.
REQ-024 wb_valid_i SHALL clear busy[wb_wa_i] at the edge; same-edge clear and set of one bit -> set wins.
REQ-025 Latency: accepted instruction appears on out_* one cycle later; back-to-back accepts sustain one per cycle.
REQ-026 wb_valid_i for a non-busy register SHALL be harmless (bit stays 0).

Reset
REQ-027 rst asserted SHALL immediately force busy_o=0, out_valid_o=0, out_op0_o=out_op1_o=0, out_wa_o=0, out_we_o=0.
REQ-028 Reset mid-operation SHALL discard the held slot and all pending busy bits; first accept after release behaves as from power-up.

Structure
REQ-029 Shared package SHALL hold DW, AW, NREG=2^AW and the zero-register index constant.
REQ-030 Scoreboard (busy bits, set/clear, eff-busy lookup) SHALL be sub-module opf_scoreboard; slot and bypass in operand_fetch.

Verification
REQ-031 Reset, then accept ra0=1, ra1=2, rd0_i=0x11, rd1_i=0x22, wa=3, we=1 -> next cycle out_op0=0x11, out_op1=0x22, out_wa=3, busy_o[3]=1.
REQ-032 busy[3]=1, present ra0=3 -> in_ready_o=0 until wb_valid_i, wb_wa=3, wb_wd=0xABCD; that cycle accepted, out_op0=0xABCD, busy[3]=0 after edge.
REQ-033 Slot FULL, out_ready_i=0 for 4 cycles -> in_ready_o=0, payload unchanged; out_ready_i=1 with new valid input -> slot reloads same edge.
REQ-034 Accept ra0=0, wa=0, we=1, rd0_i=0xFFFFFFFF -> out_op0=0, out_we=0, busy_o unchanged.
REQ-035 busy[5]=1, instruction we=1, wa=5, wb_wa=5 same cycle -> accepted, busy[5]=1 after edge.
REQ-036 Assert rst while FULL and busy[7]=1 -> out_valid_o=0 and busy_o=0 without waiting for clk.

Source files
------------

// File: rtl/operand_fetch_pkg.sv
// Shared widths, register-file geometry and slot state encoding for the operand fetch stage.
package operand_fetch_pkg;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NREG = 1 << AW;

  localparam logic [AW-1:0] ZERO_IDX = 5'd0;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/opf_scoreboard.sv
// Per-register busy bits with writeback clear, accept set, and effective-busy lookups
// that already account for a writeback landing this cycle.
module opf_scoreboard #(
  parameter int AW = operand_fetch_pkg::AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_set,
  input  logic [AW-1:0]     i_set_idx,
  input  logic              i_clr,
  input  logic [AW-1:0]     i_clr_idx,
  input  logic [AW-1:0]     i_q0_idx,
  input  logic [AW-1:0]     i_q1_idx,
  input  logic [AW-1:0]     i_q2_idx,
  output logic              o_q0_busy,
  output logic              o_q1_busy,
  output logic              o_q2_busy,
  output logic [2**AW-1:0]  o_busy
);
  import operand_fetch_pkg::*;

  localparam int NR = 2**AW;
  localparam logic [AW-1:0] ZIDX = AW'(ZERO_IDX);

  logic [NR-1:0] r_busy;
  logic [NR-1:0] w_clr_mask;
  logic [NR-1:0] w_set_mask;
  logic [NR-1:0] w_keep_mask;
  logic [NR-1:0] w_eff;

  // Decode the writeback clear and accept set into one-hot masks.
  always_comb begin
    w_clr_mask = {NR{1'b0}};
    w_set_mask = {NR{1'b0}};
    if (i_clr) begin
      w_clr_mask[i_clr_idx] = 1'b1;
    end else begin
      w_clr_mask = {NR{1'b0}};
    end
    if (i_set && (i_set_idx != ZIDX)) begin
      w_set_mask[i_set_idx] = 1'b1;
    end else begin
      w_set_mask = {NR{1'b0}};
    end
  end

  // The register 0 bit is masked everywhere so it can never report busy.
  assign w_keep_mask = {{(NR-1){1'b1}}, 1'b0};
  assign w_eff       = r_busy & ~w_clr_mask & w_keep_mask;

  assign o_q0_busy = w_eff[i_q0_idx];
  assign o_q1_busy = w_eff[i_q1_idx];
  assign o_q2_busy = w_eff[i_q2_idx];
  assign o_busy    = r_busy;

  // Busy bit update: clear first, then set, so a same-edge set wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= {NR{1'b0}};
    end else begin
      r_busy <= ((r_busy & ~w_clr_mask) | w_set_mask) & w_keep_mask;
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: hazard check against the scoreboard, writeback bypass,
// and a single registered output slot with valid/ready handshake.
module operand_fetch #(
  parameter int DW = operand_fetch_pkg::DW,
  parameter int AW = operand_fetch_pkg::AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [AW-1:0]     in_ra0_i,
  input  logic [AW-1:0]     in_ra1_i,
  input  logic [AW-1:0]     in_wa_i,
  input  logic              in_we_i,
  output logic [AW-1:0]     ra0_o,
  output logic [AW-1:0]     ra1_o,
  input  logic [DW-1:0]     rd0_i,
  input  logic [DW-1:0]     rd1_i,
  input  logic              wb_valid_i,
  input  logic [AW-1:0]     wb_wa_i,
  input  logic [DW-1:0]     wb_wd_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DW-1:0]     out_op0_o,
  output logic [DW-1:0]     out_op1_o,
  output logic [AW-1:0]     out_wa_o,
  output logic              out_we_o,
  output logic [2**AW-1:0]  busy_o
);
  import operand_fetch_pkg::*;

  localparam logic [AW-1:0] ZIDX = AW'(ZERO_IDX);

  slot_state_e   r_state;
  logic [DW-1:0] r_op0;
  logic [DW-1:0] r_op1;
  logic [AW-1:0] r_wa;
  logic          r_we;

  logic          w_eb0;
  logic          w_eb1;
  logic          w_ebw;
  logic          w_hazard;
  logic          w_ready;
  logic          w_accept;
  logic          w_set;
  logic [DW-1:0] w_op0;
  logic [DW-1:0] w_op1;

  function automatic logic [DW-1:0] sel_operand(
    input logic [AW-1:0] idx,
    input logic [DW-1:0] rd,
    input logic          wb_v,
    input logic [AW-1:0] wb_a,
    input logic [DW-1:0] wb_d
  );
    logic [DW-1:0] res;
    if (idx == ZIDX) begin
      res = {DW{1'b0}};
    end else if (wb_v && (wb_a == idx)) begin
      res = wb_d;
    end else begin
      res = rd;
    end
    return res;
  endfunction

  assign ra0_o = in_ra0_i;
  assign ra1_o = in_ra1_i;

  opf_scoreboard #(.AW(AW)) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .i_set     (w_set),
    .i_set_idx (in_wa_i),
    .i_clr     (wb_valid_i),
    .i_clr_idx (wb_wa_i),
    .i_q0_idx  (in_ra0_i),
    .i_q1_idx  (in_ra1_i),
    .i_q2_idx  (in_wa_i),
    .o_q0_busy (w_eb0),
    .o_q1_busy (w_eb1),
    .o_q2_busy (w_ebw),
    .o_busy    (busy_o)
  );

  // Hazard, handshake and bypassed operand selection.
  always_comb begin
    w_hazard = in_valid_i & (w_eb0 | w_eb1 | (in_we_i & w_ebw));
    w_ready  = ~w_hazard & ((r_state == SLOT_EMPTY) | out_ready_i);
    w_accept = in_valid_i & w_ready;
    w_set    = w_accept & in_we_i & (in_wa_i != ZIDX);
    w_op0    = sel_operand(in_ra0_i, rd0_i, wb_valid_i, wb_wa_i, wb_wd_i);
    w_op1    = sel_operand(in_ra1_i, rd1_i, wb_valid_i, wb_wa_i, wb_wd_i);
  end

  assign in_ready_o = w_ready;

  // Output slot: a new accept reloads even while draining; otherwise payload holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= SLOT_EMPTY;
      r_op0   <= {DW{1'b0}};
      r_op1   <= {DW{1'b0}};
      r_wa    <= {AW{1'b0}};
      r_we    <= 1'b0;
    end else if (w_accept) begin
      r_state <= SLOT_FULL;
      r_op0   <= w_op0;
      r_op1   <= w_op1;
      r_wa    <= in_wa_i;
      r_we    <= in_we_i & (in_wa_i != ZIDX);
    end else if ((r_state == SLOT_FULL) && out_ready_i) begin
      r_state <= SLOT_EMPTY;
    end else begin
      r_state <= r_state;
    end
  end

  assign out_valid_o = (r_state == SLOT_FULL);
  assign out_op0_o   = r_op0;
  assign out_op1_o   = r_op1;
  assign out_wa_o    = r_wa;
  assign out_we_o    = r_we;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed vector table plus randomized run against a behavioural model of the
// scoreboard, bypass and single-entry output slot.
module tb_operand_fetch;

  logic        clk;
  logic        rst;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [4:0]  in_ra0_i;
  logic [4:0]  in_ra1_i;
  logic [4:0]  in_wa_i;
  logic        in_we_i;
  logic [4:0]  ra0_o;
  logic [4:0]  ra1_o;
  logic [31:0] rd0_i;
  logic [31:0] rd1_i;
  logic        wb_valid_i;
  logic [4:0]  wb_wa_i;
  logic [31:0] wb_wd_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_op0_o;
  logic [31:0] out_op1_o;
  logic [4:0]  out_wa_o;
  logic        out_we_o;
  logic [31:0] busy_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] rf [32];
  logic        m_busy [32];
  logic        m_valid;
  logic [31:0] m_op0;
  logic [31:0] m_op1;
  logic [4:0]  m_wa;
  logic        m_we;

  assign rd0_i = rf[in_ra0_i];
  assign rd1_i = rf[in_ra1_i];

  operand_fetch #(.DW(32), .AW(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_ra0_i    (in_ra0_i),
    .in_ra1_i    (in_ra1_i),
    .in_wa_i     (in_wa_i),
    .in_we_i     (in_we_i),
    .ra0_o       (ra0_o),
    .ra1_o       (ra1_o),
    .rd0_i       (rd0_i),
    .rd1_i       (rd1_i),
    .wb_valid_i  (wb_valid_i),
    .wb_wa_i     (wb_wa_i),
    .wb_wd_i     (wb_wd_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_op0_o   (out_op0_o),
    .out_op1_o   (out_op1_o),
    .out_wa_o    (out_wa_o),
    .out_we_o    (out_we_o),
    .busy_o      (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [4:0]  wa;
    logic        we;
    logic        wbv;
    logic [4:0]  wbwa;
    logic [31:0] wbwd;
    logic        ordy;
    logic        exp_rdy;
    logic        exp_ov;
    logic [31:0] exp_op0;
    logic [31:0] exp_op1;
    logic [4:0]  exp_wa;
    logic        exp_we;
    logic [31:0] exp_busy;
  } vec_t;

  vec_t tbl [17];

  function automatic vec_t mk(
    input logic v, input logic [4:0] ra0, input logic [4:0] ra1, input logic [4:0] wa,
    input logic we, input logic wbv, input logic [4:0] wbwa, input logic [31:0] wbwd,
    input logic ordy, input logic rdy, input logic ov, input logic [31:0] op0,
    input logic [31:0] op1, input logic [4:0] owa, input logic owe, input logic [31:0] busy
  );
    vec_t r;
    r.v = v; r.ra0 = ra0; r.ra1 = ra1; r.wa = wa; r.we = we;
    r.wbv = wbv; r.wbwa = wbwa; r.wbwd = wbwd; r.ordy = ordy;
    r.exp_rdy = rdy; r.exp_ov = ov; r.exp_op0 = op0; r.exp_op1 = op1;
    r.exp_wa = owa; r.exp_we = owe; r.exp_busy = busy;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  function automatic logic m_cleared(input logic [4:0] r);
    return wb_valid_i && (wb_wa_i == r);
  endfunction

  function automatic logic m_effbusy(input logic [4:0] r);
    return (r != 5'd0) && m_busy[r] && !m_cleared(r);
  endfunction

  function automatic logic m_ready();
    logic hz;
    hz = in_valid_i && (m_effbusy(in_ra0_i) || m_effbusy(in_ra1_i) ||
                        (in_we_i && m_effbusy(in_wa_i)));
    return !hz && (!m_valid || out_ready_i);
  endfunction

  function automatic logic [31:0] m_operand(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (m_cleared(r)) return wb_wd_i;
    return rf[r];
  endfunction

  function automatic logic [31:0] m_busy_vec();
    logic [31:0] b;
    for (int i = 0; i < 32; i++) b[i] = m_busy[i];
    return b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    m_valid = 1'b0; m_op0 = 32'd0; m_op1 = 32'd0; m_wa = 5'd0; m_we = 1'b0;
  endtask

  // Called shortly after a rising edge while the pre-edge inputs are still applied.
  task automatic model_edge();
    logic        acc;
    logic [31:0] a0;
    logic [31:0] a1;
    acc = in_valid_i && m_ready();
    a0  = m_operand(in_ra0_i);
    a1  = m_operand(in_ra1_i);
    if (acc) begin
      m_valid = 1'b1; m_op0 = a0; m_op1 = a1; m_wa = in_wa_i;
      m_we = in_we_i && (in_wa_i != 5'd0);
    end else if (m_valid && out_ready_i) begin
      m_valid = 1'b0;
    end
    if (wb_valid_i) m_busy[wb_wa_i] = 1'b0;
    if (acc && in_we_i && (in_wa_i != 5'd0)) m_busy[in_wa_i] = 1'b1;
    if (wb_valid_i && (wb_wa_i != 5'd0)) rf[wb_wa_i] = wb_wd_i;
  endtask

  task automatic drive(input vec_t t);
    in_valid_i = t.v; in_ra0_i = t.ra0; in_ra1_i = t.ra1; in_wa_i = t.wa; in_we_i = t.we;
    wb_valid_i = t.wbv; wb_wa_i = t.wbwa; wb_wd_i = t.wbwd; out_ready_i = t.ordy;
  endtask

  task automatic idle();
    in_valid_i = 1'b0; in_ra0_i = 5'd0; in_ra1_i = 5'd0; in_wa_i = 5'd0; in_we_i = 1'b0;
    wb_valid_i = 1'b0; wb_wa_i = 5'd0; wb_wd_i = 32'd0; out_ready_i = 1'b0;
  endtask

  task automatic check_model_outputs(input string tag);
    chk({tag, "_out_valid"}, {31'd0, out_valid_o}, {31'd0, m_valid});
    chk({tag, "_op0"},       out_op0_o,           m_op0);
    chk({tag, "_op1"},       out_op1_o,           m_op1);
    chk({tag, "_wa"},        {27'd0, out_wa_o},   {27'd0, m_wa});
    chk({tag, "_we"},        {31'd0, out_we_o},   {31'd0, m_we});
    chk({tag, "_busy"},      busy_o,              m_busy_vec());
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, {31'd0, out_valid_o}, 32'd0);
    chk({tag, "_op0"},       out_op0_o,           32'd0);
    chk({tag, "_op1"},       out_op1_o,           32'd0);
    chk({tag, "_wa"},        {27'd0, out_wa_o},   32'd0);
    chk({tag, "_we"},        {31'd0, out_we_o},   32'd0);
    chk({tag, "_busy"},      busy_o,              32'd0);
  endtask

  initial begin
    logic [4:0] pick;
    rst = 1'b1;
    idle();
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + i;
    rf[0] = 32'hFFFF_FFFF; rf[1] = 32'h11; rf[2] = 32'h22; rf[3] = 32'h33;
    rf[4] = 32'h44; rf[5] = 32'h55; rf[6] = 32'h66; rf[7] = 32'h77;
    model_reset();

    //            v    ra0   ra1   wa    we   wbv  wbwa  wbwd           ordy rdy  ov   op0            op1       owa   owe  busy
    tbl[0]  = mk(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 5'd0, 32'd0,         1'b1, 1'b1, 1'b1, 32'h11,       32'h22,   5'd3, 1'b1, 32'h8);
    tbl[1]  = mk(1'b1, 5'd3, 5'd0, 5'd4, 1'b0, 1'b0, 5'd0, 32'd0,         1'b1, 1'b0, 1'b0, 32'h11,       32'h22,   5'd3, 1'b1, 32'h8);
    tbl[2]  = mk(1'b1, 5'd3, 5'd0, 5'd4, 1'b0, 1'b1, 5'd3, 32'hABCD,      1'b1, 1'b1, 1'b1, 32'hABCD,     32'd0,    5'd4, 1'b0, 32'h0);
    tbl[3]  = mk(1'b1, 5'd1, 5'd2, 5'd6, 1'b0, 1'b0, 5'd0, 32'd0,         1'b0, 1'b0, 1'b1, 32'hABCD,     32'd0,    5'd4, 1'b0, 32'h0);
    tbl[4]  = tbl[3];
    tbl[5]  = tbl[3];
    tbl[6]  = tbl[3];
    tbl[7]  = mk(1'b1, 5'd1, 5'd2, 5'd6, 1'b0, 1'b0, 5'd0, 32'd0,         1'b1, 1'b1, 1'b1, 32'h11,       32'h22,   5'd6, 1'b0, 32'h0);
    tbl[8]  = mk(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'd0,         1'b1, 1'b1, 1'b1, 32'd0,        32'd0,    5'd0, 1'b0, 32'h0);
    tbl[9]  = mk(1'b1, 5'd1, 5'd1, 5'd5, 1'b1, 1'b0, 5'd0, 32'd0,         1'b1, 1'b1, 1'b1, 32'h11,       32'h11,   5'd5, 1'b1, 32'h20);
    tbl[10] = mk(1'b1, 5'd2, 5'd0, 5'd5, 1'b1, 1'b1, 5'd5, 32'h5555,      1'b1, 1'b1, 1'b1, 32'h22,       32'd0,    5'd5, 1'b1, 32'h20);
    tbl[11] = mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd9, 32'h99,        1'b1, 1'b1, 1'b0, 32'h22,       32'd0,    5'd5, 1'b1, 32'h20);
    tbl[12] = mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd5, 32'h5A5A,      1'b1, 1'b1, 1'b0, 32'h22,       32'd0,    5'd5, 1'b1, 32'h0);
    tbl[13] = mk(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 5'd0, 32'd0,         1'b1, 1'b1, 1'b1, 32'd0,        32'd0,    5'd7, 1'b1, 32'h80);
    tbl[14] = mk(1'b1, 5'd0, 5'd7, 5'd1, 1'b0, 1'b0, 5'd0, 32'd0,         1'b1, 1'b0, 1'b0, 32'd0,        32'd0,    5'd7, 1'b1, 32'h80);
    tbl[15] = mk(1'b1, 5'd1, 5'd0, 5'd7, 1'b1, 1'b0, 5'd0, 32'd0,         1'b1, 1'b0, 1'b0, 32'd0,        32'd0,    5'd7, 1'b1, 32'h80);
    tbl[16] = mk(1'b1, 5'd1, 5'd0, 5'd7, 1'b0, 1'b0, 5'd0, 32'd0,         1'b1, 1'b1, 1'b1, 32'h11,       32'd0,    5'd7, 1'b0, 32'h80);

    // Reset state while rst is held.
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b0;

    // Directed vectors.
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i]);
      #1;
      chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready_o}, {31'd0, tbl[i].exp_rdy});
      chk($sformatf("v%0d_ra0", i),      {27'd0, ra0_o},      {27'd0, tbl[i].ra0});
      @(posedge clk);
      #1;
      model_edge();
      chk($sformatf("v%0d_out_valid", i), {31'd0, out_valid_o}, {31'd0, tbl[i].exp_ov});
      chk($sformatf("v%0d_op0", i),       out_op0_o,           tbl[i].exp_op0);
      chk($sformatf("v%0d_op1", i),       out_op1_o,           tbl[i].exp_op1);
      chk($sformatf("v%0d_wa", i),        {27'd0, out_wa_o},   {27'd0, tbl[i].exp_wa});
      chk($sformatf("v%0d_we", i),        {31'd0, out_we_o},   {31'd0, tbl[i].exp_we});
      chk($sformatf("v%0d_busy", i),      busy_o,              tbl[i].exp_busy);
      @(negedge clk);
    end

    // Asynchronous reset while the slot is full and register 7 is busy.
    idle();
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // First accept after reset: register 7 must no longer be busy.
    drive(mk(1'b1, 5'd7, 5'd0, 5'd7, 1'b1, 1'b0, 5'd0, 32'd0, 1'b1,
             1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0));
    #1;
    chk("post_rst_in_ready", {31'd0, in_ready_o}, 32'd1);
    @(posedge clk);
    #1;
    model_edge();
    chk("post_rst_op0",  out_op0_o, 32'h77);
    chk("post_rst_busy", busy_o,    32'h80);
    @(negedge clk);

    // Randomized traffic over a small register window to provoke hazards.
    for (int n = 0; n < 600; n++) begin
      in_valid_i  = ($urandom_range(0, 3) != 0);
      in_ra0_i    = 5'($urandom_range(0, 7));
      in_ra1_i    = 5'($urandom_range(0, 7));
      in_wa_i     = 5'($urandom_range(0, 7));
      in_we_i     = 1'($urandom_range(0, 1));
      wb_valid_i  = ($urandom_range(0, 1) == 1);
      pick        = 5'($urandom_range(0, 7));
      for (int k = 0; k < 8; k++) begin
        if (m_busy[(int'(pick) + k) % 8] && ($urandom_range(0, 3) != 0)) begin
          pick = 5'((int'(pick) + k) % 8);
          break;
        end
      end
      wb_wa_i     = pick;
      wb_wd_i     = $urandom;
      out_ready_i = ($urandom_range(0, 9) < 7);
      #1;
      chk("rnd_in_ready", {31'd0, in_ready_o}, {31'd0, m_ready()});
      chk("rnd_ra1",      {27'd0, ra1_o},      {27'd0, in_ra1_i});
      @(posedge clk);
      #1;
      model_edge();
      check_model_outputs("rnd");
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
